// File: rtl/reg_read_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_stage_pkg
//  Description : Shared constants and decode helpers for the register-read
//                (ID) stage: opcodes, register-index width, datapath width.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_read_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int REGIDX_W = 5;

    localparam logic [REGIDX_W-1:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Only these formats actually source rt; immediate-format ALU ops and
    // loads use the rt field as a destination, so it must not cause a stall.
    function automatic logic uses_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
               (opcode == OP_BNE)   || (opcode == OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_read_stage_regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : NREG x W register file, one synchronous write port, two
//                combinational read ports with r0 masking and write-through
//                bypass of the same-cycle write.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_2r1w
    import reg_read_stage_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int NREG = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_we,
    input  logic [REGIDX_W-1:0] i_waddr,
    input  logic [W-1:0]        i_wdata,
    input  logic [REGIDX_W-1:0] i_raddr_a,
    input  logic [REGIDX_W-1:0] i_raddr_b,
    output logic [W-1:0]        o_rdata_a,
    output logic [W-1:0]        o_rdata_b
);

    logic [W-1:0] r_mem [NREG];

    // Storage: clear everything on reset (reset beats a concurrent write),
    // otherwise commit the write unless it targets r0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != REG_ZERO) && (int'(i_waddr) < NREG)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports: r0 is hard zero, a same-cycle write is forwarded so the
    // reader never sees stale data while the file updates at the edge.
    always_comb begin
        o_rdata_a = r_mem[i_raddr_a];
        if (i_raddr_a == REG_ZERO) begin
            o_rdata_a = '0;
        end else if (i_we && (i_waddr == i_raddr_a)) begin
            o_rdata_a = i_wdata;
        end

        o_rdata_b = r_mem[i_raddr_b];
        if (i_raddr_b == REG_ZERO) begin
            o_rdata_b = '0;
        end else if (i_we && (i_waddr == i_raddr_b)) begin
            o_rdata_b = i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_read_stage.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_stage
//  Description : Instruction-decode register read. Decodes fields, reads
//                rs/rt with write-back bypass, detects load-use hazards and
//                registers the operands into the ID/EX boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_read_stage
    import reg_read_stage_pkg::*;
#(
    parameter int W    = DATA_W,
    parameter int NREG = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr,
    input  logic                valid_in,
    input  logic                flush,
    input  logic                regwr,
    input  logic [REGIDX_W-1:0] rw,
    input  logic [W-1:0]        busW,
    input  logic                ex_mem2reg,
    input  logic                ex_regwr,
    input  logic [REGIDX_W-1:0] ex_rw,
    output logic                stall,
    output logic                qvalid,
    output logic [W-1:0]        qbusA,
    output logic [W-1:0]        qbusB,
    output logic [REGIDX_W-1:0] qrs,
    output logic [REGIDX_W-1:0] qrt,
    output logic [REGIDX_W-1:0] qrd,
    output logic [W-1:0]        qimm,
    output logic [5:0]          qopcode,
    output logic [5:0]          qfunct
);

    logic [5:0]          w_opcode;
    logic [5:0]          w_funct;
    logic [REGIDX_W-1:0] w_rs;
    logic [REGIDX_W-1:0] w_rt;
    logic [REGIDX_W-1:0] w_rd;
    logic [W-1:0]        w_imm;
    logic [W-1:0]        w_busA;
    logic [W-1:0]        w_busB;
    logic                w_uses_rt;
    logic                w_stall;

    assign w_opcode = instr[31:26];
    assign w_rs     = instr[25:21];
    assign w_rt     = instr[20:16];
    assign w_rd     = instr[15:11];
    assign w_funct  = instr[5:0];
    assign w_imm    = {{(W-16){instr[15]}}, instr[15:0]};

    regfile_2r1w #(
        .W    (W),
        .NREG (NREG)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (regwr),
        .i_waddr   (rw),
        .i_wdata   (busW),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_busA),
        .o_rdata_b (w_busB)
    );

    // Load-use hazard: the load in EX has no data until MEM, so hold ID for
    // one cycle when it produces a register this instruction reads.
    always_comb begin
        w_uses_rt = uses_rt(w_opcode);
        w_stall   = valid_in && ex_mem2reg && ex_regwr && (ex_rw != REG_ZERO) &&
                    ((ex_rw == w_rs) || (w_uses_rt && (ex_rw == w_rt)));
    end

    assign stall = w_stall;

    // ID/EX register: reset, then flush, then stall/bubble, else capture.
    always_ff @(posedge clk) begin
        if (reset || flush || w_stall || !valid_in) begin
            qvalid  <= 1'b0;
            qbusA   <= '0;
            qbusB   <= '0;
            qrs     <= '0;
            qrt     <= '0;
            qrd     <= '0;
            qimm    <= '0;
            qopcode <= '0;
            qfunct  <= '0;
        end else begin
            qvalid  <= 1'b1;
            qbusA   <= w_busA;
            qbusB   <= w_busB;
            qrs     <= w_rs;
            qrt     <= w_rt;
            qrd     <= w_rd;
            qimm    <= w_imm;
            qopcode <= w_opcode;
            qfunct  <= w_funct;
        end
    end

endmodule
`default_nettype wire

// File: doc/reg_read_stage.md
Name: reg_read_stage

Overview:
- Decode-side reader of the register-write interface: consumes rw/busW/regwr from the write-back stage.
- Holds the 32x32 register file and reads rs/rt for the instruction in ID.
- Bypasses a same-cycle write-back into the read data.
- Detects load-use hazards, flushes on request, and registers decoded operands into the ID/EX boundary.

Parameters:
- W, 32, datapath and register width
- NREG, 32, number of architectural registers (index width fixed at 5)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  32  instruction in ID
- valid_in  in  1  instr is a real instruction, not a bubble
- flush  in  1  taken branch/jump: squash the instruction in ID
- regwr  in  1  write-back enable from write stage
- rw  in  5  write-back destination register
- busW  in  W  write-back data
- ex_mem2reg  in  1  instruction currently in EX is a load
- ex_regwr  in  1  instruction in EX writes a register
- ex_rw  in  5  destination of instruction in EX
- stall  out  1  combinational load-use stall; upstream holds PC/IF-ID
- qvalid  out  1  ID/EX valid
- qbusA  out  W  registered rs operand
- qbusB  out  W  registered rt operand
- qrs, qrt, qrd  out  5 each  registered register indices
- qimm  out  W  registered sign-extended instr[15:0]
- qopcode  out  6  registered instr[31:26]
- qfunct  out  6  registered instr[5:0]

Behaviour:
- Reset: all 32 file entries = 0; every q* output = 0; qvalid = 0. Reset wins over a simultaneous write-back.
- Field decode:
  - rs = instr[25:21], rt = instr[20:16], rd = instr[15:11].
  - qimm = {{16{instr[15]}}, instr[15:0]}.
- Register file write:
  - On posedge when regwr=1 and rw!=0: file[rw] <= busW.
  - Writes to r0 are ignored; r0 always reads 0.
- Read with write-through bypass (combinational):
  - busA = 0 if rs==0.
  - Otherwise busA = busW if regwr && rw==rs.
  - Otherwise busA = file[rs].
  - busB is computed the same way using rt.
- uses_rt is asserted for opcode R-type (0x00), BEQ (0x04), BNE (0x05) and SW (0x2B); it is 0 for all other opcodes.
- stall = valid_in && ex_mem2reg && ex_regwr && ex_rw!=0 && (ex_rw==rs || (uses_rt && ex_rw==rt)).
- ID/EX register update, one per cycle, in priority order:
  1. reset: all zero.
  2. flush: bubble (qvalid=0, all q* = 0). Flush overrides stall.
  3. stall or !valid_in: bubble.
  4. Otherwise load busA, busB, rs, rt, rd, imm, opcode, funct; qvalid = 1.
- Latency: instr at cycle N appears on q* at cycle N+1.
- stall depends only on current inputs and holds as long as the hazard exists. When EX advances, the next cycle the load is in MEM, stall drops, and the same instr is captured. It then reads the load result via bypass one cycle later, or via the file if the load has already been written.
- A write-back and an ID read of the same register in one cycle: ID sees busW through the bypass and the file updates at the edge. There is no read-before-write hazard.
- The write port is independent of stall/flush: write-back always commits (except during reset).

Decomposition:
- Shared package holds:
  - opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_LW=6'h23, OP_SW=6'h2B;
  - REG_ZERO=5'd0;
  - widths W and REGIDX_W=5.
- One sub-module, regfile_2r1w: 32xW storage with synchronous reset, one write port, two combinational read ports with r0 masking and write-through bypass.
- Hazard detection and the ID/EX register live in reg_read_stage.

Test Plan:
- Reset, then write-back regwr=1, rw=5, busW=0x1234ABCD for one cycle. Next cycle instr ADD rs=5 rt=0 valid_in=1 -> following cycle qbusA=0x1234ABCD, qbusB=0, qvalid=1.
- Same cycle regwr=1, rw=7, busW=0xDEADBEEF and instr with rs=7 -> qbusA=0xDEADBEEF next cycle (bypass).
- regwr=1, rw=0, busW=0xFFFFFFFF, then read rs=0 -> qbusA=0; also instr[15:0]=0x8001 -> qimm=0xFFFF8001.
- ex_mem2reg=1, ex_regwr=1, ex_rw=9, instr ADD rt=9 -> stall=1 and next qvalid=0.
  - Same hazard with ex_rw=9 and instr ADDI whose rt=9 (so uses_rt=0) -> stall=0.
- stall and flush both asserted -> qvalid=0 and all q*=0.
  - Next cycle, hazard gone and valid_in=1 -> instruction captured normally.
- Write r3=0x55 then assert reset for one cycle alongside regwr=1, rw=4 -> after reset, reads of r3 and r4 both return 0 and qvalid=0.
